// File: rtl/mem_write_tracer.sv
// Snoops data-port write strobes, queues in-window writes into a show-ahead trace FIFO,
// and decodes a tohost exit register into sticky done/pass/exit_code.
module mem_write_tracer #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] WIN_BASE    = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] WIN_SIZE    = 32'h0000_4000,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 32'h0000_3FFC,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        bus_addr,
  input  logic [DATA_WIDTH-1:0]        bus_wdata,
  input  logic [DATA_WIDTH/8-1:0]      bus_wenable,
  output logic                         trace_valid,
  input  logic                         trace_ready,
  output logic [ADDR_WIDTH-1:0]        trace_addr,
  output logic [DATA_WIDTH-1:0]        trace_data,
  output logic [DATA_WIDTH/8-1:0]      trace_strb,
  output logic [$clog2(DEPTH):0]       trace_level,
  output logic [CNT_WIDTH-1:0]         overflow_count,
  output logic                         done,
  output logic                         pass,
  output logic [DATA_WIDTH-2:0]        exit_code
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(DEPTH) + 1;
  localparam int IDX_W  = PTR_W - 1;

  // Window end is computed one bit wider so a window touching the top of the map cannot wrap.
  localparam logic [ADDR_WIDTH:0] WIN_END = {1'b0, WIN_BASE} + {1'b0, WIN_SIZE};

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_W-1:0]     strb;
  } entry_t;

  entry_t               mem_q [DEPTH];
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0] ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [DATA_WIDTH-2:0] exit_q, exit_d;

  logic   ev, in_win, tohost_hit, trace_hit;
  logic   empty, full, pop, push, drop;
  entry_t wr_entry, head;

  always_comb begin
    ev         = (|bus_wenable) && !done_q;
    in_win     = ({1'b0, bus_addr} >= {1'b0, WIN_BASE}) && ({1'b0, bus_addr} < WIN_END);
    tohost_hit = ev && (bus_addr == TOHOST_ADDR) && (&bus_wenable);
    trace_hit  = ev && in_win && !tohost_hit;

    empty = (wptr_q == rptr_q);
    full  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
            (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
    pop   = !empty && trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push  = trace_hit && (!full || pop);
    drop  = trace_hit && full && !pop;
  end

  always_comb begin
    wr_entry.addr = bus_addr;
    wr_entry.strb = bus_wenable;
    for (int b = 0; b < STRB_W; b++) begin
      wr_entry.data[b*8 +: 8] = bus_wenable[b] ? bus_wdata[b*8 +: 8] : 8'h00;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    done_d = done_q;
    pass_d = pass_q;
    exit_d = exit_q;
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    if (drop && (ovf_q != '1)) ovf_d = ovf_q + CNT_WIDTH'(1);
    if (tohost_hit) begin
      done_d = 1'b1;
      pass_d = (bus_wdata == DATA_WIDTH'(1));
      exit_d = bus_wdata[DATA_WIDTH-1:1];
    end
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      exit_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
      pass_q <= pass_d;
      exit_q <= exit_d;
    end
  end

  // NOTE: storage is not reset; reset empties the FIFO through the pointers and outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wptr_q[IDX_W-1:0]] <= wr_entry;
  end

  assign head = mem_q[rptr_q[IDX_W-1:0]];

  always_comb begin
    trace_valid    = !empty;
    trace_addr     = empty ? '0 : head.addr;
    trace_data     = empty ? '0 : head.data;
    trace_strb     = empty ? '0 : head.strb;
    trace_level    = wptr_q - rptr_q;
    overflow_count = ovf_q;
    done           = done_q;
    pass           = pass_q;
    exit_code      = exit_q;
  end

endmodule

// File: tb/tb_mem_write_tracer.sv
// Directed and randomized checks of mem_write_tracer against a queue-based reference model.
module tb_mem_write_tracer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam logic [AW-1:0] TOHOST = 32'h0000_3FFC;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [SW-1:0] bus_wenable;
  logic          trace_valid, trace_ready;
  logic [AW-1:0] trace_addr;
  logic [DW-1:0] trace_data;
  logic [SW-1:0] trace_strb;
  logic [$clog2(DEPTH):0] trace_level;
  logic [CW-1:0] overflow_count;
  logic          done, pass;
  logic [DW-2:0] exit_code;

  mem_write_tracer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
    .WIN_BASE(32'h0), .WIN_SIZE(32'h4000), .TOHOST_ADDR(TOHOST), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wenable(bus_wenable),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_addr(trace_addr), .trace_data(trace_data), .trace_strb(trace_strb),
    .trace_level(trace_level), .overflow_count(overflow_count),
    .done(done), .pass(pass), .exit_code(exit_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } ent_t;

  ent_t    m_q[$];
  int      m_ovf;
  bit      m_done, m_pass;
  longint  m_exit;
  int      errors = 0;
  int      checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] masked(input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic [DW-1:0] m = '0;
    for (int b = 0; b < SW; b++) if (s[b]) m = m | (DW'(8'hFF) << (8 * b));
    return d & m;
  endfunction

  // Reference update for one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    bit ev, th, hit, popped;
    ent_t e;
    if (rst) begin
      m_q.delete(); m_ovf = 0; m_done = 0; m_pass = 0; m_exit = 0;
      return;
    end
    ev  = (bus_wenable != 0) && !m_done;
    th  = ev && bus_addr == TOHOST && bus_wenable == {SW{1'b1}};
    hit = ev && !th && bus_addr < 32'h4000;
    popped = (m_q.size() > 0) && trace_ready;
    if (hit && m_q.size() == DEPTH && !popped) begin
      if (m_ovf < (1 << CW) - 1) m_ovf++;
    end
    if (popped) void'(m_q.pop_front());
    if (hit && (m_q.size() < DEPTH)) begin
      e.addr = bus_addr; e.data = masked(bus_wdata, bus_wenable); e.strb = bus_wenable;
      m_q.push_back(e);
    end
    if (th) begin
      m_done = 1; m_pass = (bus_wdata == 1); m_exit = longint'(bus_wdata) / 2;
    end
  endtask

  task automatic check_all();
    bit v = m_q.size() > 0;
    check("valid", 64'(trace_valid), 64'(v));
    check("addr",  64'(trace_addr),  v ? 64'(m_q[0].addr) : 64'd0);
    check("data",  64'(trace_data),  v ? 64'(m_q[0].data) : 64'd0);
    check("strb",  64'(trace_strb),  v ? 64'(m_q[0].strb) : 64'd0);
    check("level", 64'(trace_level), 64'(m_q.size()));
    check("ovf",   64'(overflow_count), 64'(m_ovf));
    check("done",  64'(done), 64'(m_done));
    check("pass",  64'(pass), 64'(m_pass));
    check("exit",  64'(exit_code), 64'(m_exit));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                       input logic rdy);
    bus_addr = a; bus_wdata = d; bus_wenable = s; trace_ready = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive('0, '0, '0, 1'b0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    drive('0, '0, '0, 1'b0);

    // Reset state
    do_reset();

    // Partial-strobe write masks unstrobed bytes; visible one cycle later
    drive(32'h100, 32'hDEADBEEF, 4'b0110, 1'b0);
    step();
    drive('0, '0, '0, 1'b0);
    check("t1_data", 64'(trace_data), 64'h00AD_BE00);
    check("t1_level", 64'(trace_level), 64'd1);
    step();

    // Six writes into a 4-deep FIFO: two dropped
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(32'(4 * i), 32'h1000 + 32'(i), 4'hF, 1'b0);
      step();
    end
    check("t2_level", 64'(trace_level), 64'd4);
    check("t2_ovf", 64'(overflow_count), 64'd2);
    drive('0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t2_order", 64'(trace_addr), 64'(4 * i));
      step();
    end
    check("t2_empty", 64'(trace_valid), 64'd0);

    // Push and pop on the same cycle while full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(32'(4 * i), 32'hA0 + 32'(i), 4'hF, 1'b0);
      step();
    end
    drive(32'h20, 32'h55, 4'hF, 1'b1);
    step();
    check("t3_level", 64'(trace_level), 64'd4);
    check("t3_ovf", 64'(overflow_count), 64'd0);
    drive('0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step();
    check("t3_last", 64'(trace_addr), 64'h20);
    step();

    // Overflow counter saturates
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(32'(8 * i), 32'(i), 4'b0011, 1'b0);
      step();
    end
    check("sat_ovf", 64'(overflow_count), 64'd7);

    // Exit with pass
    do_reset();
    drive(TOHOST, 32'h1, 4'hF, 1'b0);
    step();
    check("pass_done", 64'(done), 64'd1);
    check("pass_pass", 64'(pass), 64'd1);
    check("pass_level", 64'(trace_level), 64'd0);
    drive(32'h10, 32'h77, 4'hF, 1'b0);
    step();
    check("post_done_level", 64'(trace_level), 64'd0);

    // Partial tohost write is traced; full one exits with a code
    do_reset();
    drive(TOHOST, 32'hFF, 4'b0001, 1'b0);
    step();
    drive(TOHOST, 32'h2B, 4'hF, 1'b0);
    step();
    check("fail_pass", 64'(pass), 64'd0);
    check("fail_exit", 64'(exit_code), 64'h15);
    check("fail_level", 64'(trace_level), 64'd1);
    drive('0, '0, '0, 1'b1);
    step();

    // Out-of-window write ignored; reset with three entries held (and a write pending)
    do_reset();
    drive(32'h8000, 32'h1234, 4'hF, 1'b0);
    step();
    check("oow_level", 64'(trace_level), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(32'h40 + 32'(4 * i), 32'hC0 + 32'(i), 4'hF, 1'b0);
      step();
    end
    rst = 1'b1;
    drive(TOHOST, 32'h1, 4'hF, 1'b1);
    step();
    rst = 1'b0;
    check("rst_valid", 64'(trace_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] a;
      logic [SW-1:0] s;
      int sel = int'($urandom_range(0, 99));
      if (sel < 3)       a = TOHOST;
      else if (sel < 12) a = 32'h4000 + ($urandom & 32'hFFFF);
      else if (sel < 60) a = 32'(4 * $urandom_range(0, 15));
      else               a = $urandom & 32'h3FFF;
      case ($urandom_range(0, 3))
        0:       s = '0;
        1:       s = 4'hF;
        default: s = SW'($urandom);
      endcase
      rst = ($urandom_range(0, 79) == 0) || (m_done && $urandom_range(0, 7) == 0);
      drive(a, $urandom, s, $urandom_range(0, 2) != 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
